imem_init_responder: RTL and testbench

IMEM_INIT_RESPONDER -- requirements
Module: imem_init_responder

---
 rtl/imem_init_responder.sv | 188 ++++++++++++++++++
 tb/tb_imem_init_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_init_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_init_responder
// Purpose  : Single-clock instruction memory that is loaded through a
//            word-write port and then serves registered fetches to a CPU.
//            Program loading is allowed while the CPU is held in reset. The
//            memory is handed to the CPU (READY) once loading stops and reset
//            is released.
//
// Ports    : clk                            - sole clock, rising edge
//            rst                            - synchronous, active-high reset
//            initialize                     - load strobe, one word per cycle
//            instruction_initialize_address - byte address of loaded word
//            instruction_initialize_data    - loaded instruction word
//            pc                             - CPU byte fetch address
//            instruction                    - registered fetched word (NOP=0)
//            mem_ready                      - memory in READY, fetches valid
//            load_count                     - accepted writes in current load
//            fetch_fault                    - pulse, out-of-range fetch
//            addr_err                       - sticky, rejected load write
//
// Options  : IMEM_ALIGN_CHECK_EN - when defined, byte-misaligned load writes
//            are rejected and misaligned fetches fault. When undefined,
//            address bits [1:0] are ignored.
//
// Revision : 1.0 - initial release
// ============================================================================
module imem_init_responder #(
    parameter int ADDR_WORDS_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     initialize,
    input  logic [31:0]              instruction_initialize_address,
    input  logic [31:0]              instruction_initialize_data,
    input  logic [31:0]              pc,
    output logic [31:0]              instruction,
    output logic                     mem_ready,
    output logic [ADDR_WORDS_LOG2:0] load_count,
    output logic                     fetch_fault,
    output logic                     addr_err
);

    localparam int                     c_DEPTH     = 1 << ADDR_WORDS_LOG2;
    localparam logic [ADDR_WORDS_LOG2:0] c_COUNT_MAX = {1'b1, {ADDR_WORDS_LOG2{1'b0}}};

    localparam logic [1:0] c_ST_EMPTY   = 2'd0;
    localparam logic [1:0] c_ST_LOADING = 2'd1;
    localparam logic [1:0] c_ST_READY   = 2'd2;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [31:0]              r_mem [0:c_DEPTH-1];
    logic [1:0]               r_state;
    logic [ADDR_WORDS_LOG2:0] r_load_count;
    logic [31:0]              r_instruction;
    logic                     r_mem_ready;
    logic                     r_fetch_fault;
    logic                     r_addr_err;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WORDS_LOG2-1:0] w_wr_idx;
    logic [ADDR_WORDS_LOG2-1:0] w_rd_idx;
    logic                       w_wr_in_range;
    logic                       w_rd_in_range;
    logic                       w_wr_aligned;
    logic                       w_rd_aligned;
    logic                       w_wr_accept;
    logic                       w_wr_reject;
    logic                       w_rd_ok;

    assign w_wr_idx = instruction_initialize_address[ADDR_WORDS_LOG2+1:2];
    assign w_rd_idx = pc[ADDR_WORDS_LOG2+1:2];

    // Any set bit above the word index means the address lies beyond the array.
    assign w_wr_in_range = (instruction_initialize_address >> (ADDR_WORDS_LOG2 + 2)) == 32'd0;
    assign w_rd_in_range = (pc >> (ADDR_WORDS_LOG2 + 2)) == 32'd0;

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_wr_aligned = (instruction_initialize_address[1:0] == 2'b00);
    assign w_rd_aligned = (pc[1:0] == 2'b00);
`else
    // Byte-offset bits carry no meaning in this build.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{pc[1:0], instruction_initialize_address[1:0]};
    assign w_wr_aligned  = 1'b1;
    assign w_rd_aligned  = 1'b1;
`endif

    assign w_wr_accept = initialize & w_wr_in_range & w_wr_aligned;
    assign w_wr_reject = initialize & ~(w_wr_in_range & w_wr_aligned);
    assign w_rd_ok     = w_rd_in_range & w_rd_aligned;

    // ------------------------------------------------------------------
    // State sequencing
    // Reset does not force a fixed state: it only blocks the hand-over to
    // READY. A load that already holds words survives reset so the program
    // can be installed while the CPU is held in reset.
    // ------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_load_start;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_LOADING: begin
                if (!initialize) begin
                    if (!rst) begin
                        w_state_nxt = c_ST_READY;
                    end else if (r_load_count == '0) begin
                        w_state_nxt = c_ST_EMPTY;
                    end else begin
                        w_state_nxt = c_ST_LOADING;
                    end
                end
            end
            c_ST_READY: begin
                if (initialize) begin
                    w_state_nxt = c_ST_LOADING;
                end else if (rst) begin
                    w_state_nxt = c_ST_EMPTY;
                end
            end
            default: begin
                // EMPTY and any unreachable encoding
                w_state_nxt = initialize ? c_ST_LOADING : c_ST_EMPTY;
            end
        endcase
    end

    // A new load starts whenever the strobe arrives outside LOADING.
    assign w_load_start = initialize & (r_state != c_ST_LOADING);

    // ------------------------------------------------------------------
    // Storage write. Fetch reads the pre-edge contents, so a colliding
    // write and fetch return the old word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_wr_idx] <= instruction_initialize_data;
        end
    end

    // ------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;

        // Counter is deliberately not touched by rst.
        if (w_load_start) begin
            r_load_count <= w_wr_accept ? {{ADDR_WORDS_LOG2{1'b0}}, 1'b1} : '0;
        end else if (w_wr_accept && (r_load_count != c_COUNT_MAX)) begin
            r_load_count <= r_load_count + 1'b1;
        end

        if (rst) begin
            r_instruction <= 32'h0;
            r_mem_ready   <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            // Outputs describe the state entered on this edge, so the fetched
            // word is only presented alongside mem_ready.
            r_mem_ready   <= (w_state_nxt == c_ST_READY);
            r_fetch_fault <= (w_state_nxt == c_ST_READY) && !w_rd_ok;
            if ((w_state_nxt == c_ST_READY) && w_rd_ok) begin
                r_instruction <= r_mem[w_rd_idx];
            end else begin
                r_instruction <= 32'h0;
            end
            if (w_wr_reject) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign instruction = r_instruction;
    assign mem_ready   = r_mem_ready;
    assign load_count  = r_load_count;
    assign fetch_fault = r_fetch_fault;
    assign addr_err    = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_init_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_init_responder
// Purpose  : Self-checking bench for imem_init_responder: directed vector
//            table, a saturation sequence and randomized traffic compared
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_init_responder;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        initialize;
    logic [31:0] ia;
    logic [31:0] idata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        mem_ready;
    logic [AW:0] load_count;
    logic        fetch_fault;
    logic        addr_err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    imem_init_responder #(.ADDR_WORDS_LOG2(AW)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .initialize                     (initialize),
        .instruction_initialize_address (ia),
        .instruction_initialize_data    (idata),
        .pc                             (pc),
        .instruction                    (instruction),
        .mem_ready                      (mem_ready),
        .load_count                     (load_count),
        .fetch_fault                    (fetch_fault),
        .addr_err                       (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: memory as an array, mode as a plain enum, rules
    // written straight from the behavioural description.
    // ------------------------------------------------------------------
    typedef enum int {M_EMPTY, M_LOADING, M_READY} mode_t;

    mode_t       m_mode = M_EMPTY;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_count = 0;
    bit          m_count_known = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] e_instr;
    bit          e_instr_known;
    bit          e_ready;
    bit          e_fault;

    function automatic bit addr_ok(input logic [31:0] a);
        if (a >= 32'(DEPTH * 4)) return 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
        if (a % 4 != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic model_step();
        int          widx = int'(ia / 4) % DEPTH;
        int          ridx = int'(pc / 4) % DEPTH;
        bit          wr_ok = initialize && addr_ok(ia);
        bit          rd_ok = addr_ok(pc);
        logic [31:0] old = m_mem[ridx];
        bit          old_known = m_known[ridx];
        mode_t       nm;
        if (initialize)
            nm = M_LOADING;
        else if (m_mode == M_LOADING)
            nm = !rst ? M_READY : ((m_count_known && m_count == 0) ? M_EMPTY : M_LOADING);
        else if (m_mode == M_READY && rst)
            nm = M_EMPTY;
        else
            nm = m_mode;

        if (initialize && m_mode != M_LOADING) begin
            m_count       = wr_ok ? 1 : 0;
            m_count_known = 1'b1;
        end else if (wr_ok && m_count < DEPTH) begin
            m_count++;
        end

        if (rst) m_err = 1'b0;
        else if (initialize && !wr_ok) m_err = 1'b1;

        if (wr_ok) begin
            m_mem[widx]   = idata;
            m_known[widx] = 1'b1;
        end

        e_ready       = !rst && (nm == M_READY);
        e_fault       = e_ready && !rd_ok;
        e_instr       = (e_ready && rd_ok) ? old : 32'h0;
        e_instr_known = !(e_ready && rd_ok) || old_known;
        m_mode        = nm;
    endtask

    task automatic compare_model();
        chk("model.mem_ready", 32'(mem_ready), 32'(e_ready));
        chk("model.fetch_fault", 32'(fetch_fault), 32'(e_fault));
        chk("model.addr_err", 32'(addr_err), 32'(m_err));
        if (m_count_known) chk("model.load_count", 32'(load_count), 32'(m_count));
        if (e_instr_known) chk("model.instruction", instruction, e_instr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: inputs for one cycle, expected outputs after it.
    // ------------------------------------------------------------------
    typedef struct {
        bit          r;
        bit          init;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
        logic [31:0] x_instr;
        bit          x_ready;
        bit          x_fault;
        bit          x_err;
        int          x_count;   // negative: not checked
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit init, logic [31:0] a, logic [31:0] d, logic [31:0] p,
                                logic [31:0] x_instr, bit x_ready, bit x_fault, bit x_err, int x_count);
        vec_t v;
        v.r = r; v.init = init; v.a = a; v.d = d; v.p = p;
        v.x_instr = x_instr; v.x_ready = x_ready; v.x_fault = x_fault;
        v.x_err = x_err; v.x_count = x_count;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; initialize = 1'b0; ia = '0; idata = '0; pc = '0;

        //   rst init addr        data          pc          instr         rdy flt err cnt
        add(1, 0, 32'h0,   32'h0,        32'h0,   32'h0,        0, 0, 0, -1);
        add(1, 1, 32'h0,   32'h00020820, 32'h0,   32'h0,        0, 0, 0, 1);
        add(1, 1, 32'h4,   32'h00844022, 32'h0,   32'h0,        0, 0, 0, 2);
        add(1, 1, 32'h8,   32'h00A63825, 32'h0,   32'h0,        0, 0, 0, 3);
        add(1, 1, 32'hC,   32'hAC09000C, 32'h0,   32'h0,        0, 0, 0, 4);
        add(1, 1, 32'h10,  32'h8C0C000C, 32'h0,   32'h0,        0, 0, 0, 5);
        add(1, 1, 32'h14,  32'h1000FFFF, 32'h0,   32'h0,        0, 0, 0, 6);
        add(1, 0, 32'h0,   32'h0,        32'h0,   32'h0,        0, 0, 0, 6);
        add(0, 0, 32'h0,   32'h0,        32'h14,  32'h1000FFFF, 1, 0, 0, 6);
        add(0, 0, 32'h0,   32'h0,        32'h0,   32'h00020820, 1, 0, 0, 6);
        add(0, 0, 32'h0,   32'h0,        32'h4,   32'h00844022, 1, 0, 0, 6);
        add(0, 1, 32'h18,  32'h11112222, 32'h0,   32'h0,        0, 0, 0, 1);
        add(0, 1, 32'h100, 32'hDEADBEEF, 32'h0,   32'h0,        0, 0, 1, 1);
        add(0, 0, 32'h0,   32'h0,        32'h100, 32'h0,        1, 1, 1, 1);
        add(0, 0, 32'h0,   32'h0,        32'h18,  32'h11112222, 1, 0, 1, 1);
        add(0, 1, 32'h0,   32'hFFFFFFFF, 32'h0,   32'h0,        0, 0, 1, 1);
        add(0, 0, 32'h0,   32'h0,        32'h0,   32'hFFFFFFFF, 1, 0, 1, 1);
        add(1, 0, 32'h0,   32'h0,        32'h0,   32'h0,        0, 0, 0, 1);
        add(0, 0, 32'h0,   32'h0,        32'h0,   32'h0,        0, 0, 0, 1);
`ifdef IMEM_ALIGN_CHECK_EN
        add(0, 1, 32'h6,   32'h5A5A0006, 32'h0,   32'h0,        0, 0, 1, 0);
        add(0, 0, 32'h0,   32'h0,        32'h4,   32'h00844022, 1, 0, 1, 0);
        add(0, 0, 32'h0,   32'h0,        32'h8,   32'h00A63825, 1, 0, 1, 0);
        add(0, 0, 32'h0,   32'h0,        32'h14,  32'h1000FFFF, 1, 0, 1, 0);
        add(0, 0, 32'h0,   32'h0,        32'h6,   32'h0,        1, 1, 1, 0);
`else
        add(0, 1, 32'h6,   32'h5A5A0006, 32'h0,   32'h0,        0, 0, 0, 1);
        add(0, 0, 32'h0,   32'h0,        32'h4,   32'h5A5A0006, 1, 0, 0, 1);
        add(0, 0, 32'h0,   32'h0,        32'h8,   32'h00A63825, 1, 0, 0, 1);
        add(0, 0, 32'h0,   32'h0,        32'h14,  32'h1000FFFF, 1, 0, 0, 1);
        add(0, 0, 32'h0,   32'h0,        32'h6,   32'h5A5A0006, 1, 0, 0, 1);
`endif

        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].r; initialize = vecs[i].init;
            ia = vecs[i].a; idata = vecs[i].d; pc = vecs[i].p;
            tick();
            chk($sformatf("vec%0d.instruction", i), instruction, vecs[i].x_instr);
            chk($sformatf("vec%0d.mem_ready", i), 32'(mem_ready), 32'(vecs[i].x_ready));
            chk($sformatf("vec%0d.fetch_fault", i), 32'(fetch_fault), 32'(vecs[i].x_fault));
            chk($sformatf("vec%0d.addr_err", i), 32'(addr_err), 32'(vecs[i].x_err));
            if (vecs[i].x_count >= 0)
                chk($sformatf("vec%0d.load_count", i), 32'(load_count), 32'(vecs[i].x_count));
        end

        // Fill every word, then one extra write: the counter must stop at DEPTH.
        rst = 1'b0; initialize = 1'b1;
        for (int w = 0; w < DEPTH; w++) begin
            ia = 32'(w * 4); idata = $urandom; pc = 32'($urandom_range(0, 255));
            tick();
        end
        chk("sat.full_load_count", 32'(load_count), 32'(DEPTH));
        ia = 32'h0; idata = $urandom;
        tick();
        chk("sat.load_count", 32'(load_count), 32'(DEPTH));
        initialize = 1'b0; pc = 32'h0;
        tick();
        chk("sat.mem_ready", 32'(mem_ready), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) initialize = ~initialize;
            ia    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            idata = $urandom;
            pc    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
